// File: rtl/nano_io_port_if.sv
// rtl/nano_io_port_if.sv - controller and external-device signal bundle for nano_io_port
interface nano_io_port_if;
   logic       LdOUTPUT;
   logic [7:0] DataOut;
   logic       RdINPUT;
   logic       InAck;
   logic [7:0] DataIn;
   logic       InValid;
   logic       Busy;
   logic       Overflow;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport slave (
      input  LdOUTPUT, DataOut, RdINPUT, InAck, out_ready, in_data, in_valid,
      output DataIn, InValid, Busy, Overflow, out_data, out_valid, in_ready
   );

   modport master (
      output LdOUTPUT, DataOut, RdINPUT, InAck, out_ready, in_data, in_valid,
      input  DataIn, InValid, Busy, Overflow, out_data, out_valid, in_ready
   );
endinterface

// File: rtl/nano_io_port.sv
// rtl/nano_io_port.sv - output byte FIFO plus single-byte input capture FSM
module nano_io_port #(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   nano_io_port_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          full, pop, push;

   assign full = (count_q == CW'(DEPTH));
   assign pop  = (count_q != '0) && bus.out_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push = bus.LdOUTPUT && (!full || pop);

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (bus.LdOUTPUT && full && !pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.DataOut;
   end

   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.out_valid = (count_q != '0);
   assign bus.Busy      = full;
   assign bus.Overflow  = overflow_q;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t     state_q;
   logic [7:0] data_in_q;
   logic       in_valid_q;
   logic       in_ready_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         data_in_q  <= 8'h00;
         in_valid_q <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.RdINPUT) begin
                  state_q    <= S_WAIT;
                  in_ready_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.in_valid && in_ready_q) begin
                  state_q    <= S_HOLD;
                  data_in_q  <= bus.in_data;
                  in_valid_q <= 1'b1;
                  in_ready_q <= 1'b0;
               end
            end
            S_HOLD: begin
               if (bus.InAck) begin
                  state_q    <= S_IDLE;
                  in_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               in_valid_q <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.DataIn   = data_in_q;
   assign bus.InValid  = in_valid_q;
   assign bus.in_ready = in_ready_q;
endmodule

// File: tb/tb_nano_io_port.sv
// tb/tb_nano_io_port.sv - directed vector bench for nano_io_port
module tb_nano_io_port;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   nano_io_port_if bus ();

   nano_io_port #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [7:0] dout;
      logic       rd;
      logic       ack;
      logic       ordy;
      logic [7:0] idat;
      logic       ival;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_busy;
      logic       e_ovf;
      logic       e_inv;
      logic [7:0] e_din;
      logic       e_irdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ld, logic [7:0] dout, logic rd, logic ack, logic ordy,
                               logic [7:0] idat, logic ival, logic e_ov, logic [7:0] e_od,
                               logic e_busy, logic e_ovf, logic e_inv, logic [7:0] e_din,
                               logic e_irdy);
      vec_t v;
      v.ld = ld; v.dout = dout; v.rd = rd; v.ack = ack; v.ordy = ordy;
      v.idat = idat; v.ival = ival; v.e_ov = e_ov; v.e_od = e_od;
      v.e_busy = e_busy; v.e_ovf = e_ovf; v.e_inv = e_inv; v.e_din = e_din;
      v.e_irdy = e_irdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] dout, input logic rd, input logic ack,
                        input logic ordy, input logic [7:0] idat, input logic ival);
      bus.LdOUTPUT  = ld;
      bus.DataOut   = dout;
      bus.RdINPUT   = rd;
      bus.InAck     = ack;
      bus.out_ready = ordy;
      bus.in_data   = idat;
      bus.in_valid  = ival;
   endtask

   // Data bytes are only compared where the matching valid flag is expected high.
   task automatic apply(input vec_t v, input int idx);
      logic [31:0] act, exp;
      @(negedge clk);
      drive(v.ld, v.dout, v.rd, v.ack, v.ordy, v.idat, v.ival);
      @(posedge clk);
      #1;
      act = {8'h0, bus.out_valid, bus.Busy, bus.Overflow, bus.InValid, bus.in_ready,
             3'b0, (v.e_ov ? bus.out_data : 8'h00), (v.e_inv ? bus.DataIn : 8'h00)};
      exp = {8'h0, v.e_ov, v.e_busy, v.e_ovf, v.e_inv, v.e_irdy,
             3'b0, (v.e_ov ? v.e_od : 8'h00), (v.e_inv ? v.e_din : 8'h00)};
      chk($sformatf("vec%0d", idx), act, exp);
   endtask

   logic [7:0] model[$];
   logic       ordy_r, ld_r, popped, pushed;

   initial begin
      // fifo ordering, three bytes
      vecs.push_back(mk(1, 8'h11, 0, 0, 0, 8'h00, 0, 1, 8'h11, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'h22, 0, 0, 0, 8'h00, 0, 1, 8'h11, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'h33, 0, 0, 0, 8'h00, 0, 1, 8'h11, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'h22, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'h33, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
      // full fifo, push with simultaneous pop
      vecs.push_back(mk(1, 8'hA1, 0, 0, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'hA2, 0, 0, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'hA3, 0, 0, 0, 8'h00, 0, 1, 8'hA1, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 8'h00, 0, 1, 8'hA1, 1, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'hA5, 0, 0, 1, 8'h00, 0, 1, 8'hA2, 1, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'hA3, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'hA4, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'hA5, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
      // input handshake and ignored controls
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'hA5, 1, 0, 8'h00, 0, 0, 1, 8'hA5, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h5A, 1, 0, 8'h00, 0, 0, 1, 8'hA5, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h33, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h3C, 1, 0, 8'h00, 0, 0, 1, 8'h3C, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
      // overflow: fifth push dropped, sticky flag
      vecs.push_back(mk(1, 8'h44, 0, 0, 0, 8'h00, 0, 1, 8'h44, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'h55, 0, 0, 0, 8'h00, 0, 1, 8'h44, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'h66, 0, 0, 0, 8'h00, 0, 1, 8'h44, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'h77, 0, 0, 0, 8'h00, 0, 1, 8'h44, 1, 0, 0, 8'h00, 0));
      vecs.push_back(mk(1, 8'h88, 0, 0, 0, 8'h00, 0, 1, 8'h44, 1, 1, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'h55, 0, 1, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'h66, 0, 1, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 8'h77, 0, 1, 0, 8'h00, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0));

      rst = 1'b0;
      drive(0, 8'h00, 0, 0, 0, 8'h00, 0);
      #1;
      chk("reset_outputs", {bus.out_valid, bus.Busy, bus.Overflow, bus.InValid, bus.in_ready, bus.DataIn},
          {5'b00000, 8'h00});
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) apply(vecs[i], i);

      // asynchronous reset while holding an input byte with two bytes queued
      @(negedge clk); drive(1, 8'hC1, 1, 0, 0, 8'h00, 0);
      @(negedge clk); drive(1, 8'hC2, 0, 0, 0, 8'h00, 0);
      @(negedge clk); drive(0, 8'h00, 0, 0, 0, 8'hD7, 1);
      @(negedge clk); drive(0, 8'h00, 0, 0, 0, 8'h00, 0);
      chk("pre_reset_state", {bus.out_valid, bus.out_data, bus.InValid, bus.DataIn, bus.Overflow},
          {1'b1, 8'hC1, 1'b1, 8'hD7, 1'b1});
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset", {bus.out_valid, bus.Busy, bus.Overflow, bus.InValid, bus.in_ready, bus.DataIn},
          {5'b00000, 8'h00});
      @(negedge clk);
      rst = 1'b1;
      drive(1, 8'hE9, 0, 0, 0, 8'h00, 0);
      @(posedge clk); #1;
      chk("post_reset_push", {bus.out_valid, bus.out_data, bus.InValid, bus.in_ready},
          {1'b1, 8'hE9, 1'b0, 1'b0});
      @(negedge clk); drive(0, 8'h00, 0, 0, 1, 8'h00, 0);
      @(posedge clk); #1;
      chk("post_reset_count", {bus.out_valid, bus.Overflow}, 2'b00);

      // random out_ready, data order across pointer wrap
      model.delete();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         ordy_r = 1'($urandom_range(0, 1));
         ld_r   = ($urandom_range(0, 3) != 0) && (model.size() < 4 || ordy_r);
         drive(ld_r, 8'h60 + 8'(i), 0, 0, ordy_r, 8'h00, 0);
         if (model.size() > 0)
            chk($sformatf("rand_head%0d", i), {bus.out_valid, bus.out_data}, {1'b1, model[0]});
         else
            chk($sformatf("rand_empty%0d", i), {31'b0, bus.out_valid}, 32'b0);
         popped = ordy_r && (model.size() > 0);
         pushed = ld_r && (model.size() < 4 || popped);
         @(posedge clk);
         if (popped) void'(model.pop_front());
         if (pushed) model.push_back(8'h60 + 8'(i));
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(0, 8'h00, 0, 0, 1, 8'h00, 0);
         if (model.size() > 0)
            chk($sformatf("drain_head%0d", i), {bus.out_valid, bus.out_data}, {1'b1, model[0]});
         else
            chk($sformatf("drain_empty%0d", i), {31'b0, bus.out_valid}, 32'b0);
         @(posedge clk);
         if (model.size() > 0) void'(model.pop_front());
      end
      #1;
      chk("rand_no_overflow", {31'b0, bus.Overflow}, 32'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nano_io_port.md
NANO_IO_PORT -- requirements
Module: nano_io_port

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries; power of two, at least 2.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 LdOUTPUT  in  1  controller pulse: push DataOut into output FIFO.
REQ-005 DataOut  in  8  register value to be output.
REQ-006 RdINPUT  in  1  controller pulse: request one input byte.
REQ-007 InAck  in  1  controller has consumed DataIn.
REQ-008 DataIn  out  8  captured input byte, registered.
REQ-009 InValid  out  1  DataIn holds an unconsumed byte.
REQ-010 Busy  out  1  output FIFO full; controller stalls OUTPUT.
REQ-011 Overflow  out  1  sticky flag: a push was dropped.
REQ-012 out_data  out  8  FIFO head byte to external device.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_ready  in  1  external device accepts out_data.
REQ-015 in_data  in  8  byte from external device.
REQ-016 in_valid  in  1  in_data valid.
REQ-017 in_ready  out  1  port will accept in_data, registered.

Function
REQ-018 Output FIFO: circular buffer of DEPTH x 8, read and write pointers that wrap modulo DEPTH, occupancy count 0..DEPTH.
REQ-019 Pop: occurs in any cycle with out_valid=1 and out_ready=1; the read pointer advances by one.
REQ-020 Push: occurs when LdOUTPUT=1 and either count<DEPTH or a pop occurs in the same cycle; DataOut is written at the write pointer, and the write pointer advances.
REQ-021 Dropped push: LdOUTPUT=1 with count=DEPTH and no pop in that cycle drops the push and sets Overflow to 1; Overflow clears only on reset.
REQ-022 Simultaneous push and pop: count is unchanged.
REQ-023 Push into an empty FIFO: out_valid=1 and out_data equal the pushed byte on the next cycle (latency 1); there is no same-cycle bypass.
REQ-024 out_valid = (count != 0); out_data = entry at the read pointer; both are stable while out_ready=0.
REQ-025 Busy = (count == DEPTH).
REQ-026 Input FSM has three states: IDLE, WAIT, HOLD.
REQ-027 IDLE: in_ready=0, InValid=0; RdINPUT=1 -> WAIT, with in_ready=1 on the next cycle.
REQ-028 WAIT: in_ready=1; a cycle with in_valid=1 and in_ready=1 captures in_data into DataIn and -> HOLD; on the next cycle in_ready=0 and InValid=1.
REQ-029 HOLD: InValid=1 and DataIn is frozen; InAck=1 -> IDLE, with InValid=0 on the next cycle; in_valid is ignored.
REQ-030 RdINPUT in WAIT or HOLD is ignored; it is neither queued nor counted.
REQ-031 InAck in IDLE or WAIT is ignored.
REQ-032 Output FIFO and input FSM are independent and operate concurrently.

Reset
REQ-033 rst=0 immediately forces: FSM=IDLE, pointers=0, count=0, DataIn=8'h00, InValid=0, in_ready=0, out_valid=0, Busy=0, Overflow=0.
REQ-034 Reset mid-operation discards FIFO contents and any in-progress input transfer; FIFO memory contents need not be cleared.
REQ-035 After rst returns to 1, the first active clock edge behaves as normal operation from the reset state.

Verification
REQ-036 Push 8'h11, 8'h22, 8'h33 with out_ready=0, then raise out_ready -> out_data reads 11, 22, 33 on consecutive cycles; out_valid=0 afterwards.
REQ-037 Push 4 bytes with out_ready=0 -> Busy=1; a fifth push -> Overflow=1, count stays 4; draining yields only the first 4 bytes.
REQ-038 FIFO full, LdOUTPUT=1 and out_ready=1 in the same cycle -> push accepted, count stays 4, Overflow stays 0.
REQ-039 RdINPUT pulse, then in_valid=1 with in_data=8'hA5 two cycles later -> DataIn=A5 and InValid=1 one cycle after the transfer; in_ready=0; InAck clears InValid on the next cycle.
REQ-040 Assert rst=0 while the FSM is in HOLD and FIFO count=2 -> all outputs go to reset values asynchronously; FSM returns to IDLE and count to 0.
REQ-041 12 push/pop cycles with random out_ready -> data order preserved across pointer wrap-around and no spurious Overflow.
